// File: rtl/ifetch_queue_if.sv
// Dispatch-side and instruction-cache-side signals of the instruction fetch queue.
// The queue itself connects through the slave modport.
interface ifetch_queue_if;
    logic        Dispatch_jmp;
    logic [31:0] Dispatch_jmp_addr;
    logic        Dispatch_ren;
    logic [31:0] ifetch_pc_4;
    logic [31:0] ifetch_intruction;
    logic        ifetch_empty;
    logic [31:0] Icache_addr;
    logic        Icache_rd_en;
    logic [31:0] Icache_data;

    modport slave (
        input  Dispatch_jmp,
        input  Dispatch_jmp_addr,
        input  Dispatch_ren,
        input  Icache_data,
        output ifetch_pc_4,
        output ifetch_intruction,
        output ifetch_empty,
        output Icache_addr,
        output Icache_rd_en
    );

    modport master (
        output Dispatch_jmp,
        output Dispatch_jmp_addr,
        output Dispatch_ren,
        output Icache_data,
        input  ifetch_pc_4,
        input  ifetch_intruction,
        input  ifetch_empty,
        input  Icache_addr,
        input  Icache_rd_en
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: owns the fetch PC, streams sequential I-cache reads into a
// circular FIFO of {PC+4, instr}, flushes on jump. Define IFQ_BYPASS_EN for empty-queue bypass.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clock,
    input  logic          reset,
    ifetch_queue_if.slave ifq
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

    logic [31:0]      fetchPc_q, fetchPc_d;
    logic [31:0]      inflightPc_q, inflightPc_d;
    logic             inflight_q, inflight_d;
    logic             squash_q, squash_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] pc4Mem_q   [DEPTH];
    logic [31:0] instrMem_q [DEPTH];

    logic [CNT_W:0] credit;
    logic           reqValid;
    logic           respValid;
    logic [31:0]    respPc4;
    logic           bypassHit;
    logic           writeEn;
    logic           popEn;
    logic           headValid;
    logic [31:0]    headPc4;
    logic [31:0]    headInstr;

    // The in-flight request holds a credit so its response always finds a free slot.
    always_comb begin
        credit    = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
        reqValid  = !reset && !ifq.Dispatch_jmp && (credit < DEPTH_V);
        respValid = inflight_q && !squash_q && !ifq.Dispatch_jmp;
        respPc4   = inflightPc_q + 32'd4;
`ifdef IFQ_BYPASS_EN
        bypassHit = respValid && (count_q == '0);
`else
        bypassHit = 1'b0;
`endif
        popEn     = ifq.Dispatch_ren && (count_q != '0) && !ifq.Dispatch_jmp;
        writeEn   = respValid && !(bypassHit && ifq.Dispatch_ren);
    end

    always_comb begin
        headValid = 1'b0;
        headPc4   = 32'd0;
        headInstr = 32'd0;
        if (count_q != '0) begin
            headValid = 1'b1;
            headPc4   = pc4Mem_q[rdPtr_q];
            headInstr = instrMem_q[rdPtr_q];
        end
`ifdef IFQ_BYPASS_EN
        else if (bypassHit) begin
            headValid = 1'b1;
            headPc4   = respPc4;
            headInstr = ifq.Icache_data;
        end
`endif
    end

    assign ifq.ifetch_empty      = !headValid;
    assign ifq.ifetch_pc_4       = headPc4;
    assign ifq.ifetch_intruction = headInstr;
    assign ifq.Icache_addr       = fetchPc_q;
    assign ifq.Icache_rd_en      = reqValid;

    always_comb begin
        fetchPc_d    = fetchPc_q;
        inflightPc_d = inflightPc_q;
        inflight_d   = 1'b0;
        squash_d     = 1'b0;
        rdPtr_d      = rdPtr_q;
        wrPtr_d      = wrPtr_q;
        count_d      = count_q;

        if (ifq.Dispatch_jmp) begin
            // A jump wipes the queue; any response still on the bus is dropped.
            fetchPc_d = ifq.Dispatch_jmp_addr & 32'hFFFF_FFFC;
            squash_d  = inflight_q;
            rdPtr_d   = '0;
            wrPtr_d   = '0;
            count_d   = '0;
        end else begin
            if (reqValid) begin
                inflight_d   = 1'b1;
                inflightPc_d = fetchPc_q;
                fetchPc_d    = fetchPc_q + 32'd4;
            end
            if (writeEn) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (popEn) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            case ({writeEn, popEn})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetchPc_q    <= RESET_PC;
            inflightPc_q <= 32'd0;
            inflight_q   <= 1'b0;
            squash_q     <= 1'b0;
            rdPtr_q      <= '0;
            wrPtr_q      <= '0;
            count_q      <= '0;
        end else begin
            fetchPc_q    <= fetchPc_d;
            inflightPc_q <= inflightPc_d;
            inflight_q   <= inflight_d;
            squash_q     <= squash_d;
            rdPtr_q      <= rdPtr_d;
            wrPtr_q      <= wrPtr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset; entries are only visible while count_q covers them.
    always_ff @(posedge clock) begin
        if (!reset && writeEn) begin
            pc4Mem_q[wrPtr_q]   <= respPc4;
            instrMem_q[wrPtr_q] <= ifq.Icache_data;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus random traffic against a
// queue-based reference model. Define IFQ_BYPASS_EN for both bench and design to cover bypass.
module tb_ifetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] instr;
    } entry_t;

    logic clock = 1'b0;
    logic reset;

    ifetch_queue_if ifq();

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .ifq   (ifq)
    );

    always #5 clock = ~clock;

    entry_t      modelQ[$];
    logic [31:0] modelPc;
    logic        modelPend;
    logic [31:0] modelPendPc;
    logic        memReq;
    logic [31:0] memAddr;
    logic        modelBypass;
    logic        modelEmpty;
    int          checkCount = 0;
    int          passCount  = 0;
    int          failCount  = 0;

    function automatic logic [31:0] imemWord(input logic [31:0] a);
        return (a >> 2) + 32'h100;
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected outputs come from the model's queue and pending-response record.
    task automatic checkOutput(input logic rst, input logic jmp);
        logic        expRdEn;
        logic [31:0] expPc4;
        logic [31:0] expInstr;
        expRdEn = !rst && !jmp && ((modelQ.size() + int'(modelPend)) < DEPTH);
`ifdef IFQ_BYPASS_EN
        modelBypass = !rst && !jmp && modelPend && (modelQ.size() == 0);
`else
        modelBypass = 1'b0;
`endif
        if (modelQ.size() > 0) begin
            modelEmpty = 1'b0;
            expPc4     = modelQ[0].pc4;
            expInstr   = modelQ[0].instr;
        end else if (modelBypass) begin
            modelEmpty = 1'b0;
            expPc4     = modelPendPc + 32'd4;
            expInstr   = ifq.Icache_data;
        end else begin
            modelEmpty = 1'b1;
            expPc4     = 32'd0;
            expInstr   = 32'd0;
        end
        checkEq("rd_en", 32'(ifq.Icache_rd_en), 32'(expRdEn));
        checkEq("icache_addr", ifq.Icache_addr, modelPc);
        checkEq("empty", 32'(ifq.ifetch_empty), 32'(modelEmpty));
        checkEq("pc_4", ifq.ifetch_pc_4, expPc4);
        checkEq("instr", ifq.ifetch_intruction, expInstr);
        checkEq("no_overflow", 32'(dut.count_q <= DEPTH), 32'd1);
    endtask

    task automatic updateModel(input logic rst, input logic jmp, input logic [31:0] addr,
                               input logic ren, input logic rdEn);
        entry_t e;
        if (rst) begin
            modelQ.delete();
            modelPc   = RESET_PC;
            modelPend = 1'b0;
        end else if (jmp) begin
            modelQ.delete();
            modelPc   = {addr[31:2], 2'b00};
            modelPend = 1'b0;
        end else begin
            if (!(modelBypass && ren)) begin
                if (ren && modelQ.size() > 0) void'(modelQ.pop_front());
                if (modelPend) begin
                    e.pc4   = modelPendPc + 32'd4;
                    e.instr = ifq.Icache_data;
                    modelQ.push_back(e);
                end
            end
            if (rdEn) begin
                modelPend   = 1'b1;
                modelPendPc = modelPc;
                modelPc     = modelPc + 32'd4;
            end else begin
                modelPend = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive inputs, answer last cycle's fetch, check, advance the model.
    task automatic applyStimulus(input logic rst, input logic jmp, input logic [31:0] addr,
                                 input logic ren);
        logic expRdEn;
        @(negedge clock);
        reset                 = rst;
        ifq.Dispatch_jmp      = jmp;
        ifq.Dispatch_jmp_addr = addr;
        ifq.Dispatch_ren      = ren;
        ifq.Icache_data       = memReq ? imemWord(memAddr) : $urandom;
        #1;
        checkOutput(rst, jmp);
        expRdEn = !rst && !jmp && ((modelQ.size() + int'(modelPend)) < DEPTH);
        memReq  = ifq.Icache_rd_en;
        memAddr = ifq.Icache_addr;
        updateModel(rst, jmp, addr, ren, expRdEn);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        rRst, rJmp, rRen;
        int          r;
        reset                 = 1'b1;
        ifq.Dispatch_jmp      = 1'b0;
        ifq.Dispatch_jmp_addr = 32'd0;
        ifq.Dispatch_ren      = 1'b0;
        ifq.Icache_data       = 32'd0;
        memReq                = 1'b0;
        memAddr               = 32'd0;
        modelPc               = RESET_PC;
        modelPend             = 1'b0;
        modelPendPc           = 32'd0;
        modelBypass           = 1'b0;
        modelEmpty            = 1'b1;

        $display("[TB] streaming fetch with continuous dispatch");
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 1);

        $display("[TB] fill to full, then drain across pointer wrap");
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 1);

        $display("[TB] jump with three entries and one fetch in flight");
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 20 && !(modelQ.size() == 3 && modelPend); i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 32'h43, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1);

        $display("[TB] back-to-back jumps");
        applyStimulus(0, 1, 32'h80, 1);
        applyStimulus(0, 1, 32'h200, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1);

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 20 && !(modelQ.size() == 2 && modelPend); i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1);

        $display("[TB] empty queue with dispatch reading every cycle");
        applyStimulus(0, 1, 32'h1000, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 500; i++) begin
            r    = $urandom_range(0, 99);
            rRst = (r < 2);
            rJmp = (r >= 2 && r < 8);
            rRen = ((i / 40) % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
            applyStimulus(rRst, rJmp, $urandom, rRen);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Instruction fetch queue (IFQ) directly upstream of the dispatch unit. Owns the fetch PC and issues sequential reads to the instruction memory. Buffers returned instructions with their PC+4 in a small circular FIFO and presents the head entry to dispatch. Redirects fetch and flushes all buffered or in-flight instructions when dispatch signals a jump or a taken branch.

Parameters:
DEPTH, 4, number of queue entries; must be a power of 2, at least 2
RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
Dispatch_jmp  in  1  1 = jump or taken branch; flush the queue and redirect fetch
Dispatch_jmp_addr  in  32  redirect target; bits [1:0] ignored and treated as 0
Dispatch_ren  in  1  1 = dispatch consumes the head entry this cycle
ifetch_pc_4  out  32  PC+4 of the head instruction
ifetch_intruction  out  32  head instruction word
ifetch_empty  out  1  1 = no valid head entry (outputs invalid)
Icache_addr  out  32  word-aligned fetch address
Icache_rd_en  out  1  fetch request strobe
Icache_data  in  32  instruction word; valid exactly 1 cycle after Icache_rd_en

Behaviour:
- State:
  - fetch_pc[31:0]
  - rd_ptr, wr_ptr: log2(DEPTH) bits each
  - count: 0..DEPTH
  - inflight flag with inflight_pc
  - squash flag
  - storage: DEPTH x {pc_4[31:0], instr[31:0]}
- Reset (reset=1 at a clock edge): fetch_pc=RESET_PC; ptrs=0; count=0; inflight=0; squash=0.
- Reset outputs: ifetch_empty=1; ifetch_pc_4=0; ifetch_intruction=0; Icache_rd_en=0; Icache_addr=RESET_PC.
- Reset mid-operation discards all entries and any in-flight response.
- Request:
  - Icache_rd_en = !reset && !Dispatch_jmp && (count + inflight < DEPTH).
  - Icache_addr = fetch_pc.
  - On request: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps mod 2^32); otherwise inflight<=0.
- Response: in the cycle after a request, Icache_data is written at wr_ptr as {inflight_pc+4, Icache_data}, then wr_ptr++ and count++. Skipped if squash=1 or Dispatch_jmp=1.
- Latency: request in cycle N; entry visible to dispatch (ifetch_empty=0) in cycle N+2.
- Throughput: one instruction per cycle in steady state.
- Pop: Dispatch_ren && !ifetch_empty → rd_ptr++, count--. Dispatch_ren while empty is ignored.
- Simultaneous write and pop: count unchanged; both pointers advance.
- Full (count=DEPTH): no request issued.
- Credit rule: the inflight slot is counted, so a response always has a free entry. Overflow is impossible; the bench asserts this.
- Wrap-around: pointers wrap mod DEPTH; no bubble at wrap.
- Head outputs: when count>0, ifetch_pc_4/ifetch_intruction = entry[rd_ptr]; when empty, both are 0.
- Redirect (Dispatch_jmp=1 at a clock edge), all in that same edge:
  - ptrs=0; count=0
  - fetch_pc={Dispatch_jmp_addr[31:2],2'b00}
  - squash<=inflight (drop a response arriving next cycle)
  - no request issued; pop and write that cycle ignored
  - first request from the target in cycle N+1; its entry visible in N+3
- squash clears in the cycle the squashed response is dropped.
- Back-to-back Dispatch_jmp: the last one wins; each re-flushes.
- Reset has priority over Dispatch_jmp. Dispatch_jmp has priority over pop and write.

Optional Feature:
IFQ_BYPASS_EN
- Defined:
  - When count=0 and a non-squashed response arrives, ifetch_empty=0 that same cycle and the outputs show {inflight_pc+4, Icache_data} combinationally.
  - If Dispatch_ren=1 that cycle, the response is consumed and not written; count stays 0.
  - Visible latency becomes N+1.
- Not defined: no combinational path from Icache_data to the outputs; latency is N+2.

Test Plan:
1. Reset, RESET_PC=0, imem[i]=i+0x100, Dispatch_ren=1 continuous → Icache_addr 0,4,8…; first ifetch_empty=0 at cycle 3 after reset release; head stream (pc_4, instr) = (4,0x100),(8,0x101),(12,0x102)… one per cycle.
2. Dispatch_ren=0 → count reaches 4; Icache_rd_en=0 while full. Raise Dispatch_ren → entries pop in order with no loss across pointer wrap; fetch resumes with no gap.
3. Queue holding 3 entries plus one in flight, pulse Dispatch_jmp with addr 0x43 → ifetch_empty=1 next cycle; in-flight word dropped; next Icache_addr=0x40; next head pc_4=0x44.
4. Dispatch_jmp asserted two consecutive cycles (0x80 then 0x200) → no entry from 0x80 ever appears; first head pc_4=0x204.
5. Reset asserted mid-stream with count=2 and a fetch in flight → next cycle ifetch_empty=1, outputs 0, Icache_addr=RESET_PC; stale response not enqueued.
6. With IFQ_BYPASS_EN, empty queue and Dispatch_ren=1 → response word visible and popped the same cycle as Icache_data; count stays 0.
